// File: rtl/oled_rect_fill_ctrl.sv
// Rectangle-fill sequencer owning the OLED pixel-write port; the CPU wins every
// cycle it writes, and the fill engine rasters its rectangle in the gaps.
module oled_rect_fill_ctrl #(
  parameter int N_COLS = 96,
  parameter int N_ROWS = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        fill_start,
  input  logic [6:0]  fill_col0,
  input  logic [6:0]  fill_col1,
  input  logic [5:0]  fill_row0,
  input  logic [5:0]  fill_row1,
  input  logic [23:0] fill_colour,
  input  logic        fill_abort,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        fill_err,
  input  logic        cpu_write,
  input  logic [6:0]  cpu_col,
  input  logic [5:0]  cpu_row,
  input  logic [23:0] cpu_data,
  output logic        OLED_Write,
  output logic [6:0]  OLED_Col,
  output logic [5:0]  OLED_Row,
  output logic [23:0] OLED_Data
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_FILL = 1'b1;

  localparam logic [31:0] COL_LIMIT = N_COLS;
  localparam logic [31:0] ROW_LIMIT = N_ROWS;

  logic        state_reg;
  logic [6:0]  col0_reg, col1_reg, cur_col_reg;
  logic [5:0]  row0_reg, row1_reg, cur_row_reg;
  logic [23:0] colour_reg;
  logic        done_reg, err_reg;
  logic        write_reg;
  logic [6:0]  col_reg;
  logic [5:0]  row_reg;
  logic [23:0] data_reg;

  logic cmd_valid;
  logic fill_issue;
  logic last_pixel;

  assign cmd_valid = (fill_col0 <= fill_col1) && (32'(fill_col1) < COL_LIMIT) &&
                     (fill_row0 <= fill_row1) && (32'(fill_row1) < ROW_LIMIT);

  // The fill only gets the port in cycles the CPU leaves free.
  assign fill_issue = (state_reg == STATE_FILL) && !cpu_write;
  assign last_pixel = (cur_col_reg == col1_reg) && (cur_row_reg == row1_reg);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= STATE_IDLE;
      col0_reg    <= '0;
      col1_reg    <= '0;
      row0_reg    <= '0;
      row1_reg    <= '0;
      cur_col_reg <= '0;
      cur_row_reg <= '0;
      colour_reg  <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      write_reg   <= 1'b0;
      col_reg     <= '0;
      row_reg     <= '0;
      data_reg    <= '0;
    end else begin
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      write_reg <= cpu_write | fill_issue;

      if (cpu_write) begin
        col_reg  <= cpu_col;
        row_reg  <= cpu_row;
        data_reg <= cpu_data;
      end else if (fill_issue) begin
        col_reg  <= cur_col_reg;
        row_reg  <= cur_row_reg;
        data_reg <= colour_reg;
      end

      case (state_reg)
        STATE_IDLE: begin
          if (fill_start) begin
            if (cmd_valid) begin
              col0_reg    <= fill_col0;
              col1_reg    <= fill_col1;
              row0_reg    <= fill_row0;
              row1_reg    <= fill_row1;
              colour_reg  <= fill_colour;
              cur_col_reg <= fill_col0;
              cur_row_reg <= fill_row0;
              state_reg   <= STATE_FILL;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        default: begin
          // An abort still lets this cycle's pixel reach the port, but never signals done.
          if (fill_abort) begin
            state_reg <= STATE_IDLE;
          end else if (fill_issue) begin
            if (last_pixel) begin
              state_reg <= STATE_IDLE;
              done_reg  <= 1'b1;
            end else if (cur_col_reg != col1_reg) begin
              cur_col_reg <= cur_col_reg + 7'd1;
            end else begin
              cur_col_reg <= col0_reg;
              cur_row_reg <= cur_row_reg + 6'd1;
            end
          end
        end
      endcase
    end
  end

  assign fill_busy  = (state_reg == STATE_FILL);
  assign fill_done  = done_reg;
  assign fill_err   = err_reg;
  assign OLED_Write = write_reg;
  assign OLED_Col   = col_reg;
  assign OLED_Row   = row_reg;
  assign OLED_Data  = data_reg;

endmodule

// File: tb/tb_oled_rect_fill_ctrl.sv
// Bench for oled_rect_fill_ctrl: a pixel-list reference model is checked every
// cycle, with table-driven commands, hand-written corner sequences and random traffic.
module tb_oled_rect_fill_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        fill_start, fill_abort;
  logic [6:0]  fill_col0, fill_col1;
  logic [5:0]  fill_row0, fill_row1;
  logic [23:0] fill_colour;
  logic        fill_busy, fill_done, fill_err;
  logic        cpu_write;
  logic [6:0]  cpu_col;
  logic [5:0]  cpu_row;
  logic [23:0] cpu_data;
  logic        OLED_Write;
  logic [6:0]  OLED_Col;
  logic [5:0]  OLED_Row;
  logic [23:0] OLED_Data;

  oled_rect_fill_ctrl #(.N_COLS(96), .N_ROWS(64)) dut (
    .CLK(CLK), .RESET(RESET),
    .fill_start(fill_start), .fill_col0(fill_col0), .fill_col1(fill_col1),
    .fill_row0(fill_row0), .fill_row1(fill_row1), .fill_colour(fill_colour),
    .fill_abort(fill_abort), .fill_busy(fill_busy), .fill_done(fill_done),
    .fill_err(fill_err), .cpu_write(cpu_write), .cpu_col(cpu_col),
    .cpu_row(cpu_row), .cpu_data(cpu_data), .OLED_Write(OLED_Write),
    .OLED_Col(OLED_Col), .OLED_Row(OLED_Row), .OLED_Data(OLED_Data)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: a fill is simply the list of pixels still owed.
  typedef struct { logic [6:0] col; logic [5:0] row; } pix_t;
  pix_t        pix_q[$];
  bit          m_active;
  logic [23:0] m_colour;
  logic        m_write, m_busy, m_done, m_err;
  logic [6:0]  m_col;
  logic [5:0]  m_row;
  logic [23:0] m_data;

  int n_writes, n_done, n_err, n_busy;

  typedef struct {
    logic [6:0]  c0, c1;
    logic [5:0]  r0, r1;
    logic [23:0] colour;
    int          exp_writes;
    bit          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    pix_t p;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_write = 1'b0;
    if (RESET) begin
      pix_q.delete();
      m_active = 1'b0;
      m_col = '0; m_row = '0; m_data = '0;
      m_busy = 1'b0;
      return;
    end
    if (cpu_write) begin
      m_write = 1'b1; m_col = cpu_col; m_row = cpu_row; m_data = cpu_data;
    end
    if (m_active) begin
      if (!cpu_write && pix_q.size() > 0) begin
        p = pix_q.pop_front();
        m_write = 1'b1; m_col = p.col; m_row = p.row; m_data = m_colour;
        if (pix_q.size() == 0 && !fill_abort) begin
          m_done = 1'b1;
          m_active = 1'b0;
        end
      end
      if (fill_abort) begin
        m_active = 1'b0;
        pix_q.delete();
      end
    end else if (fill_start) begin
      if (fill_col0 <= fill_col1 && fill_col1 < 96 && fill_row0 <= fill_row1 && fill_row1 < 64) begin
        for (int r = fill_row0; r <= fill_row1; r++)
          for (int c = fill_col0; c <= fill_col1; c++) begin
            p.col = 7'(c); p.row = 6'(r);
            pix_q.push_back(p);
          end
        m_colour = fill_colour;
        m_active = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    m_busy = m_active;
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check("oled_write", OLED_Write, m_write);
    check("fill_busy", fill_busy, m_busy);
    check("fill_done", fill_done, m_done);
    check("fill_err", fill_err, m_err);
    check("oled_col", OLED_Col, m_col);
    check("oled_row", OLED_Row, m_row);
    check("oled_data", OLED_Data, m_data);
    if (OLED_Write) n_writes++;
    if (fill_done)  n_done++;
    if (fill_err)   n_err++;
    if (fill_busy)  n_busy++;
  endtask

  task automatic clear_inputs();
    fill_start = 1'b0; fill_abort = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic clear_counts();
    n_writes = 0; n_done = 0; n_err = 0; n_busy = 0;
  endtask

  task automatic set_cmd(input logic [6:0] c0, input logic [6:0] c1,
                         input logic [5:0] r0, input logic [5:0] r1, input logic [23:0] colour);
    fill_col0 = c0; fill_col1 = c1; fill_row0 = r0; fill_row1 = r1; fill_colour = colour;
  endtask

  task automatic run_until_idle(input int budget);
    int k = 0;
    while (fill_busy && k < budget) begin
      cycle();
      k++;
    end
    check("fill_timeout", fill_busy, 1'b0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{7'd10, 7'd12, 6'd5,  6'd6,  24'hFF0000, 6,    1'b0};
    vecs[1] = '{7'd0,  7'd95, 6'd0,  6'd63, 24'h00FF00, 6144, 1'b0};
    vecs[2] = '{7'd20, 7'd10, 6'd0,  6'd0,  24'h0000FF, 0,    1'b1};
    vecs[3] = '{7'd0,  7'd96, 6'd0,  6'd0,  24'h0000FF, 0,    1'b1};
    vecs[4] = '{7'd95, 7'd95, 6'd63, 6'd63, 24'hABCDEF, 1,    1'b0};
    vecs[5] = '{7'd95, 7'd95, 6'd0,  6'd63, 24'h111111, 64,   1'b0};
    vecs[6] = '{7'd0,  7'd0,  6'd10, 6'd5,  24'h222222, 0,    1'b1};
    vecs[7] = '{7'd0,  7'd127,6'd0,  6'd0,  24'h333333, 0,    1'b1};

    clear_inputs();
    set_cmd(7'd0, 7'd0, 6'd0, 6'd0, 24'h0);
    cpu_col = '0; cpu_row = '0; cpu_data = '0;
    RESET = 1'b1;
    cycle();
    cycle();
    RESET = 1'b0;

    // Idle after reset: nothing moves.
    clear_counts();
    for (int i = 0; i < 20; i++) cycle();
    check("idle_writes", n_writes, 0);
    $display("idle: 20 cycles writes=%0d", n_writes);

    for (int v = 0; v < 8; v++) begin
      clear_counts();
      set_cmd(vecs[v].c0, vecs[v].c1, vecs[v].r0, vecs[v].r1, vecs[v].colour);
      fill_start = 1'b1;
      cycle();
      fill_start = 1'b0;
      run_until_idle(7000);
      cycle();
      check("vec_writes", n_writes, vecs[v].exp_writes);
      check("vec_err", n_err, 32'(vecs[v].exp_err));
      check("vec_done", n_done, vecs[v].exp_err ? 0 : 1);
      check("vec_busy_cycles", n_busy, vecs[v].exp_writes);
      $display("vec %0d: cols %0d..%0d rows %0d..%0d writes=%0d err=%0d done=%0d",
               v, vecs[v].c0, vecs[v].c1, vecs[v].r0, vecs[v].r1, n_writes, n_err, n_done);
    end

    // CPU interleave: two CPU pixels after the second fill pixel delay done by 2.
    clear_counts();
    set_cmd(7'd0, 7'd3, 6'd0, 6'd0, 24'hC0FFEE);
    fill_start = 1'b1;
    cycle();
    fill_start = 1'b0;
    cycle();
    cycle();
    cpu_write = 1'b1; cpu_col = 7'd50; cpu_row = 6'd20; cpu_data = 24'h123456;
    cycle();
    cycle();
    cpu_write = 1'b0;
    cycle();
    cycle();
    check("ilv_done", n_done, 1);
    check("ilv_writes", n_writes, 6);
    check("ilv_busy_cycles", n_busy, 6);
    $display("interleave: writes=%0d done=%0d busy_cycles=%0d", n_writes, n_done, n_busy);

    // Start while busy is ignored without an error.
    clear_counts();
    set_cmd(7'd0, 7'd7, 6'd1, 6'd1, 24'h445566);
    fill_start = 1'b1;
    cycle();
    cycle();
    set_cmd(7'd30, 7'd31, 6'd2, 6'd2, 24'h778899);
    cycle();
    set_cmd(7'd31, 7'd30, 6'd2, 6'd2, 24'h778899);
    cycle();
    fill_start = 1'b0;
    run_until_idle(50);
    check("busy_start_writes", n_writes, 8);
    check("busy_start_err", n_err, 0);
    $display("start while busy: writes=%0d err=%0d", n_writes, n_err);

    // Abort: the 4th pixel issued alongside the abort still lands, then silence.
    clear_counts();
    set_cmd(7'd0, 7'd3, 6'd0, 6'd3, 24'h0F0F0F);
    fill_start = 1'b1;
    cycle();
    fill_start = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    fill_abort = 1'b1;
    cycle();
    fill_abort = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check("abort_writes", n_writes, 4);
    check("abort_done", n_done, 0);
    $display("abort: writes=%0d done=%0d", n_writes, n_done);

    // Start and abort together in idle: the start wins.
    clear_counts();
    set_cmd(7'd40, 7'd41, 6'd9, 6'd9, 24'h5A5A5A);
    fill_start = 1'b1; fill_abort = 1'b1;
    cycle();
    clear_inputs();
    run_until_idle(20);
    check("start_abort_writes", n_writes, 2);
    $display("start+abort idle: writes=%0d done=%0d", n_writes, n_done);

    // Reset mid-fill, then a normal fill.
    clear_counts();
    set_cmd(7'd0, 7'd15, 6'd0, 6'd15, 24'h010203);
    fill_start = 1'b1;
    cycle();
    fill_start = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    RESET = 1'b1; cpu_write = 1'b1;
    cycle();
    RESET = 1'b0; cpu_write = 1'b0;
    check("rst_busy", fill_busy, 1'b0);
    clear_counts();
    cycle();
    check("rst_no_done", n_done, 0);
    set_cmd(7'd2, 7'd3, 6'd4, 6'd4, 24'hFEDCBA);
    fill_start = 1'b1;
    cycle();
    fill_start = 1'b0;
    run_until_idle(20);
    check("post_rst_writes", n_writes, 2);
    check("post_rst_done", n_done, 1);
    $display("reset mid-fill: post-reset writes=%0d done=%0d", n_writes, n_done);

    // Random traffic against the model.
    clear_counts();
    for (int i = 0; i < 4000; i++) begin
      logic [6:0] c0;
      logic [5:0] r0;
      c0 = 7'($urandom_range(0, 100));
      r0 = 6'($urandom_range(0, 63));
      set_cmd(c0, 7'(c0 + 7'($urandom_range(0, 8))), r0,
              6'(r0 + 6'($urandom_range(0, 4))), 24'($urandom));
      fill_start = ($urandom_range(0, 19) == 0);
      fill_abort = ($urandom_range(0, 149) == 0);
      cpu_write  = ($urandom_range(0, 3) == 0);
      cpu_col    = 7'($urandom);
      cpu_row    = 6'($urandom);
      cpu_data   = 24'($urandom);
      RESET      = ($urandom_range(0, 999) == 0);
      cycle();
    end
    clear_inputs();
    RESET = 1'b0;
    run_until_idle(200);
    $display("random: writes=%0d done=%0d err=%0d", n_writes, n_done, n_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
